// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen encoding, difficulty limit and time-load helper
package game_pkg;

  typedef enum logic [2:0] {
    TITLE  = 3'd0,
    SELECT = 3'd1,
    PLAY   = 3'd2,
    HIT    = 3'd3,
    WIN    = 3'd4,
    LOSE   = 3'd5
  } screen_t;

  localparam int MAX_DIFF = 3;

  // Seconds granted for a difficulty level; arguments default to the standard game tuning.
  function automatic logic [7:0] time_for(input logic [1:0] diff,
                                          input int base_time = 120,
                                          input int time_step = 30);
    return 8'(base_time - time_step * int'(diff));
  endfunction

endpackage

// File: rtl/game_timer.sv
// rtl/game_timer.sv - frame-to-second divider and remaining-seconds down-counter
module game_timer #(
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       run,
  input  logic       frame_tick,
  output logic [7:0] time_left,
  output logic       expire_pulse
);

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  logic [FW-1:0] frame_cnt;
  logic          wrap;

  assign wrap = run && frame_tick && (frame_cnt == FW'(FRAMES_PER_SEC - 1));
  // Flags the wrap whose decrement lands on zero, so the FSM can leave PLAY on the same edge.
  assign expire_pulse = wrap && !load && (time_left <= 8'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_left <= 8'd0;
      frame_cnt <= '0;
    end else if (load) begin
      time_left <= load_val;
      frame_cnt <= '0;
    end else if (run && frame_tick) begin
      if (wrap) begin
        frame_cnt <= '0;
        if (time_left != 8'd0) time_left <= time_left - 8'd1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - game screen sequencer owning lives, difficulty, timer and motion gate
module game_flow_controller
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int BASE_TIME      = 120,
  parameter int TIME_STEP      = 30,
  parameter int START_LIVES    = 3,
  parameter int HIT_FRAMES     = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       press,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       goal_hit,
  input  logic       enemy_hit,
  output screen_t    screen,
  output logic [1:0] sel_row,
  output logic [1:0] difficulty,
  output logic [1:0] lives,
  output logic [7:0] time_left,
  output logic       move_en,
  output logic       respawn
);

  localparam int HW = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

  if ((BASE_TIME - TIME_STEP * MAX_DIFF) < 0 || BASE_TIME > 255) begin : g_bad_time
    $error("game_flow_controller: time load out of 8-bit range for some difficulty");
  end
  if (START_LIVES < 0 || START_LIVES > 3 || HIT_FRAMES < 1 || FRAMES_PER_SEC < 1) begin : g_bad_cfg
    $error("game_flow_controller: START_LIVES, HIT_FRAMES or FRAMES_PER_SEC out of range");
  end

  logic press_q, up_q, down_q;
  logic press_rise, up_rise, down_rise;
  logic [HW-1:0] hit_cnt, hit_cnt_d;
  screen_t screen_d;
  logic [1:0] sel_row_d, difficulty_d, lives_d;
  logic respawn_d;
  logic t_load, t_run, expire;
  logic [7:0] t_load_val;

  assign press_rise = press & ~press_q;
  assign up_rise    = key_up & ~up_q;
  assign down_rise  = key_down & ~down_q;

  // Timer controls sit outside the FSM process so expire never feeds back into its own source.
  assign t_run      = (screen == PLAY) && !goal_hit && !enemy_hit;
  assign t_load     = ((screen == SELECT) && press_rise) ||
                      ((screen == PLAY) && !goal_hit && enemy_hit);
  assign t_load_val = (screen == SELECT) ? time_for(sel_row, BASE_TIME, TIME_STEP) : time_left;

  game_timer #(.FRAMES_PER_SEC(FRAMES_PER_SEC)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .load        (t_load),
    .load_val    (t_load_val),
    .run         (t_run),
    .frame_tick  (frame_tick),
    .time_left   (time_left),
    .expire_pulse(expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      screen     <= TITLE;
      sel_row    <= 2'd0;
      difficulty <= 2'd0;
      lives      <= 2'd0;
      move_en    <= 1'b0;
      respawn    <= 1'b0;
      hit_cnt    <= '0;
      press_q    <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
    end else begin
      screen     <= screen_d;
      sel_row    <= sel_row_d;
      difficulty <= difficulty_d;
      lives      <= lives_d;
      move_en    <= (screen_d == PLAY);
      respawn    <= respawn_d;
      hit_cnt    <= hit_cnt_d;
      press_q    <= press;
      up_q       <= key_up;
      down_q     <= key_down;
    end
  end

  always_comb begin
    screen_d     = screen;
    sel_row_d    = sel_row;
    difficulty_d = difficulty;
    lives_d      = lives;
    respawn_d    = 1'b0;
    hit_cnt_d    = hit_cnt;
    case (screen)
      TITLE: begin
        if (press_rise) begin
          screen_d  = SELECT;
          sel_row_d = 2'd0;
        end
      end
      SELECT: begin
        // A confirm outranks any arrow edge arriving with it.
        if (press_rise) begin
          screen_d     = PLAY;
          difficulty_d = sel_row;
          lives_d      = 2'(START_LIVES);
          respawn_d    = 1'b1;
        end else if (up_rise && !down_rise) begin
          if (sel_row != 2'd0) sel_row_d = sel_row - 2'd1;
        end else if (down_rise && !up_rise) begin
          if (sel_row != 2'(MAX_DIFF)) sel_row_d = sel_row + 2'd1;
        end
      end
      PLAY: begin
        if (goal_hit) begin
          screen_d = WIN;
        end else if (enemy_hit) begin
          screen_d  = HIT;
          hit_cnt_d = '0;
          if (lives != 2'd0) lives_d = lives - 2'd1;
        end else if (expire) begin
          screen_d = LOSE;
        end
      end
      HIT: begin
        if (frame_tick) begin
          if (hit_cnt == HW'(HIT_FRAMES - 1)) begin
            hit_cnt_d = '0;
            if (lives == 2'd0) begin
              screen_d = LOSE;
            end else begin
              screen_d  = PLAY;
              respawn_d = 1'b1;
            end
          end else begin
            hit_cnt_d = hit_cnt + 1'b1;
          end
        end
      end
      WIN, LOSE: begin
        if (press_rise) screen_d = TITLE;
      end
      default: screen_d = TITLE;
    endcase
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// tb/tb_game_flow_controller.sv - directed table-driven bench for game_flow_controller
module tb_game_flow_controller;
  import game_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0, press = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic goal_hit = 1'b0, enemy_hit = 1'b0;
  screen_t screen;
  logic [1:0] sel_row, difficulty, lives;
  logic [7:0] time_left;
  logic move_en, respawn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_flow_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .press(press),
    .key_up(key_up), .key_down(key_down), .goal_hit(goal_hit), .enemy_hit(enemy_hit),
    .screen(screen), .sel_row(sel_row), .difficulty(difficulty), .lives(lives),
    .time_left(time_left), .move_en(move_en), .respawn(respawn)
  );

  // Expected outputs packed as {screen, sel_row, difficulty, lives, time_left, move_en, respawn}.
  typedef struct packed {
    logic [5:0]  in;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [18:0] pk(input logic [2:0] scr, input logic [1:0] sel,
                                     input logic [1:0] diff, input logic [1:0] liv,
                                     input logic [7:0] tl, input logic men, input logic rsp);
    return {scr, sel, diff, liv, tl, men, rsp};
  endfunction

  // Input bits: {press, key_up, key_down, goal_hit, enemy_hit, frame_tick}.
  task automatic add(input logic [5:0] in, input logic [18:0] exp);
    vec_t v;
    v.in = in;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [18:0] exp);
    logic [18:0] got;
    got = {screen, sel_row, difficulty, lives, time_left, move_en, respawn};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got scr=%0d sel=%0d diff=%0d lives=%0d tl=%0d men=%0b rsp=%0b want scr=%0d sel=%0d diff=%0d lives=%0d tl=%0d men=%0b rsp=%0b",
               name, got[18:16], got[15:14], got[13:12], got[11:10], got[9:2], got[1], got[0],
               exp[18:16], exp[15:14], exp[13:12], exp[11:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input logic [5:0] in);
    {press, key_up, key_down, goal_hit, enemy_hit, frame_tick} = in;
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] I0 = 6'b000000, IP = 6'b100000, IU = 6'b010000, ID = 6'b001000;
  localparam logic [5:0] IG = 6'b000100, IE = 6'b000010, IT = 6'b000001;

  initial begin
    logic [7:0] tl_exp;
    // ---- table: navigation, select corner cases, win path, start at difficulty 3 ----
    add(IP, pk(SELECT, 0, 0, 0, 0, 0, 0));
    add(I0, pk(SELECT, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      add(ID, pk(SELECT, (i >= 2) ? 2'd3 : 2'(i + 1), 0, 0, 0, 0, 0));
      add(I0, pk(SELECT, (i >= 2) ? 2'd3 : 2'(i + 1), 0, 0, 0, 0, 0));
    end
    for (int i = 0; i < 4; i++) begin
      add(IU, pk(SELECT, (i >= 2) ? 2'd0 : 2'(2 - i), 0, 0, 0, 0, 0));
      add(I0, pk(SELECT, (i >= 2) ? 2'd0 : 2'(2 - i), 0, 0, 0, 0, 0));
    end
    add(ID, pk(SELECT, 1, 0, 0, 0, 0, 0));
    add(I0, pk(SELECT, 1, 0, 0, 0, 0, 0));
    add(IU | ID, pk(SELECT, 1, 0, 0, 0, 0, 0));
    add(I0, pk(SELECT, 1, 0, 0, 0, 0, 0));
    add(ID, pk(SELECT, 2, 0, 0, 0, 0, 0));
    add(I0, pk(SELECT, 2, 0, 0, 0, 0, 0));
    add(IP | ID, pk(PLAY, 2, 2, 3, 60, 1, 1));
    add(I0, pk(PLAY, 2, 2, 3, 60, 1, 0));
    add(IG | IE, pk(WIN, 2, 2, 3, 60, 0, 0));
    add(I0, pk(WIN, 2, 2, 3, 60, 0, 0));
    add(IP, pk(TITLE, 2, 2, 3, 60, 0, 0));
    add(I0, pk(TITLE, 2, 2, 3, 60, 0, 0));
    add(IP, pk(SELECT, 0, 2, 3, 60, 0, 0));
    add(I0, pk(SELECT, 0, 2, 3, 60, 0, 0));
    for (int i = 1; i <= 3; i++) begin
      add(ID, pk(SELECT, 2'(i), 2, 3, 60, 0, 0));
      add(I0, pk(SELECT, 2'(i), 2, 3, 60, 0, 0));
    end
    add(IP, pk(PLAY, 3, 3, 3, 30, 1, 1));
    add(I0, pk(PLAY, 3, 3, 3, 30, 1, 0));

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", pk(TITLE, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", pk(TITLE, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].in);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ---- timer run-down at difficulty 3: 30 s x 60 frames ----
    for (int i = 1; i <= 1800; i++) begin
      step(IT);
      tl_exp = 8'(30 - i / 60);
      if (i % 60 == 0 || i == 1)
        check($sformatf("timer_tick%0d", i),
              pk((i == 1800) ? LOSE : PLAY, 3, 3, 3, tl_exp, (i < 1800), 0));
      step(I0);
    end
    for (int i = 0; i < 3; i++) begin
      step(IT);
      check("lose_timer_frozen", pk(LOSE, 3, 3, 3, 0, 0, 0));
    end

    // ---- three enemy hits from difficulty 0 ----
    step(IP); check("lose_to_title", pk(TITLE, 3, 3, 3, 0, 0, 0));
    step(I0);
    step(IP); check("title_to_select", pk(SELECT, 0, 3, 3, 0, 0, 0));
    step(I0);
    step(IP); check("start_diff0", pk(PLAY, 0, 0, 3, 120, 1, 1));
    step(I0);
    for (int h = 0; h < 3; h++) begin
      step(IE);
      check($sformatf("hit%0d_enter", h), pk(HIT, 0, 0, 2'(2 - h), 120, 0, 0));
      for (int k = 1; k <= 60; k++) begin
        step(IT | ((k < 10) ? IE : I0) | ((k < 5) ? IG : I0));
        if (k == 59)
          check($sformatf("hit%0d_hold", h), pk(HIT, 0, 0, 2'(2 - h), 120, 0, 0));
      end
      if (h < 2) begin
        check($sformatf("hit%0d_respawn", h), pk(PLAY, 0, 0, 2'(2 - h), 120, 1, 1));
        step(I0);
        check($sformatf("hit%0d_respawn_end", h), pk(PLAY, 0, 0, 2'(2 - h), 120, 1, 0));
      end else begin
        check("hit_last_lose", pk(LOSE, 0, 0, 0, 120, 0, 0));
      end
    end

    // ---- asynchronous reset in HIT with press held through it ----
    step(IP); step(I0);
    step(IP); step(I0);
    step(IP); step(I0);
    step(IE); check("pre_reset_hit", pk(HIT, 0, 0, 2, 120, 0, 0));
    for (int k = 0; k < 20; k++) step(IT);
    step(IP);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", pk(TITLE, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("reset_held", pk(TITLE, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_edge", pk(SELECT, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      step(IP);
      check("held_press_no_repeat", pk(SELECT, 0, 0, 0, 0, 0, 0));
    end
    step(I0);
    step(IP); check("repress_start", pk(PLAY, 0, 0, 3, 120, 1, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
